// File: rtl/sport_steal_arb_pkg.sv
// Shared constants for the serial-port autobuffer steal arbiter: channel indices,
// FSM encoding and the fixed service priority.
package sport_steal_arb_pkg;

  localparam int unsigned NUM_CH = 4;

  localparam logic [1:0] CH_R0 = 2'd0;
  localparam logic [1:0] CH_T0 = 2'd1;
  localparam logic [1:0] CH_R1 = 2'd2;
  localparam logic [1:0] CH_T1 = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArb   = 2'd1,
    StSteal = 2'd2
  } arb_state_e;

  // Highest priority first.
  localparam logic [1:0] PRI_ORDER [NUM_CH] = '{CH_R0, CH_T0, CH_R1, CH_T1};

endpackage

// File: rtl/sport_pri_enc.sv
// Fixed-priority encoder over the four autobuffer channels; yields a one-hot grant
// and the matching channel index.
module sport_pri_enc
  import sport_steal_arb_pkg::*;
(
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[PRI_ORDER[i]]) begin
        found               = 1'b1;
        grant[PRI_ORDER[i]] = 1'b1;
        idx                 = PRI_ORDER[i];
      end
    end
  end

endmodule

// File: rtl/sport_steal_arb.sv
// Serial-port autobuffer cycle-steal arbiter: latches word requests, schedules
// one-cycle DMA steals for the DAG and converts wraps into completion interrupts.
module sport_steal_arb
  import sport_steal_arb_pkg::*;
(
  input  logic       DSPCLK,
  input  logic       T_RST,
  input  logic       GO_C,
  input  logic       STBY,
  input  logic [3:0] ABEN,
  input  logic [3:0] REQ,
  input  logic [2:0] R0IREG,
  input  logic [2:0] R1IREG,
  input  logic [2:0] T0IREG,
  input  logic [2:0] T1IREG,
  input  logic [1:0] R0MREG,
  input  logic [1:0] R1MREG,
  input  logic [1:0] T0MREG,
  input  logic [1:0] T1MREG,
  input  logic [3:0] WRAP,
  input  logic [3:0] OVR_CLR,
  output logic [3:0] Sreqx,
  output logic       SREQ,
  output logic       STEAL,
  output logic [3:0] sack,
  output logic [2:0] STEALI,
  output logic [1:0] STEALM,
  output logic [3:0] ABINT,
  output logic [3:0] OVR
);

  arb_state_e state_q;
  logic [3:0] req_set;
  logic [3:0] sreqx_d;
  logic [3:0] ovr_d;
  logic [3:0] grant_oh;
  logic [1:0] grant_idx;
  logic [2:0] i_sel;
  logic [1:0] m_sel;

  assign SREQ    = |Sreqx;
  assign req_set = REQ & ABEN;

  // A new word wins over the acknowledge of the previous one; ABEN low flushes.
  always_comb begin
    sreqx_d = ((Sreqx & ~sack) | req_set) & ABEN;
    ovr_d   = (OVR & ~OVR_CLR) | (req_set & Sreqx & ~sack);
  end

  always_ff @(posedge DSPCLK) begin
    if (T_RST) begin
      Sreqx <= '0;
      OVR   <= '0;
    end else begin
      Sreqx <= sreqx_d;
      OVR   <= ovr_d;
    end
  end

  sport_pri_enc u_pri_enc (
    .req   (Sreqx),
    .grant (grant_oh),
    .idx   (grant_idx)
  );

  always_comb begin
    i_sel = '0;
    m_sel = '0;
    case (grant_idx)
      CH_R0:   begin i_sel = R0IREG; m_sel = R0MREG; end
      CH_T0:   begin i_sel = T0IREG; m_sel = T0MREG; end
      CH_R1:   begin i_sel = R1IREG; m_sel = R1MREG; end
      CH_T1:   begin i_sel = T1IREG; m_sel = T1MREG; end
      default: begin i_sel = '0;     m_sel = '0;     end
    endcase
  end

  always_ff @(posedge DSPCLK) begin
    if (T_RST) begin
      state_q <= StIdle;
      STEAL   <= 1'b0;
      sack    <= '0;
      STEALI  <= '0;
      STEALM  <= '0;
      ABINT   <= '0;
    end else begin
      STEAL <= 1'b0;
      sack  <= '0;
      ABINT <= '0;
      case (state_q)
        StIdle: begin
          if (SREQ) state_q <= StArb;
        end
        StArb: begin
          if (!SREQ) begin
            state_q <= StIdle;
          end else if (GO_C && !STBY) begin
            state_q <= StSteal;
            STEAL   <= 1'b1;
            sack    <= grant_oh;
            STEALI  <= i_sel;
            STEALM  <= m_sel;
          end
        end
        StSteal: begin
          // Only the granted channel's wrap can raise its interrupt.
          ABINT   <= WRAP & sack;
          state_q <= (|sreqx_d) ? StArb : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sport_steal_arb.sv
// Directed bench for sport_steal_arb with hand-computed expectations.
module tb_sport_steal_arb;

  logic       clk;
  logic       rst;
  logic       go_c;
  logic       stby;
  logic [3:0] aben;
  logic [3:0] req;
  logic [2:0] r0i, r1i, t0i, t1i;
  logic [1:0] r0m, r1m, t0m, t1m;
  logic [3:0] wrap;
  logic [3:0] ovr_clr;
  logic [3:0] sreqx;
  logic       sreq;
  logic       steal;
  logic [3:0] sack;
  logic [2:0] steali;
  logic [1:0] stealm;
  logic [3:0] abint;
  logic [3:0] ovr;

  int checks;
  int failures;

  sport_steal_arb dut (
    .DSPCLK  (clk),
    .T_RST   (rst),
    .GO_C    (go_c),
    .STBY    (stby),
    .ABEN    (aben),
    .REQ     (req),
    .R0IREG  (r0i),
    .R1IREG  (r1i),
    .T0IREG  (t0i),
    .T1IREG  (t1i),
    .R0MREG  (r0m),
    .R1MREG  (r1m),
    .T0MREG  (t0m),
    .T1MREG  (t1m),
    .WRAP    (wrap),
    .OVR_CLR (ovr_clr),
    .Sreqx   (sreqx),
    .SREQ    (sreq),
    .STEAL   (steal),
    .sack    (sack),
    .STEALI  (steali),
    .STEALM  (stealm),
    .ABINT   (abint),
    .OVR     (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] pri_sack [4];
  logic [2:0] pri_i    [4];
  logic [1:0] pri_m    [4];

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; go_c = 1'b1; stby = 1'b0; aben = 4'h0; req = 4'h0;
    r0i = 3'd5; t0i = 3'd1; r1i = 3'd2; t1i = 3'd7;
    r0m = 2'd2; t0m = 2'd1; r1m = 2'd3; t1m = 2'd0;
    wrap = 4'h0; ovr_clr = 4'h0;
    pri_sack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    pri_i    = '{3'd5, 3'd1, 3'd2, 3'd7};
    pri_m    = '{2'd2, 2'd1, 2'd3, 2'd0};

    // Reset state
    tick(); tick();
    check("rst_outputs", {sreqx, sreq, steal, sack, steali, stealm, abint, ovr}, 0);
    rst = 1'b0;

    // REQ with ABEN=0 is ignored
    req = 4'b0001; tick(); req = 4'h0;
    check("aben0_ignored", sreqx, 4'h0);
    aben = 4'hF;

    // Single request R0
    req = 4'b0001; tick(); req = 4'h0;
    check("single_sreqx", {sreqx, sreq, steal}, {4'b0001, 1'b1, 1'b0});
    tick();
    check("single_arb_nosteal", steal, 1'b0);
    tick();
    check("single_steal", {steal, sack, steali, stealm}, {1'b1, 4'b0001, 3'd5, 2'd2});
    tick();
    check("single_after", {steal, sack, sreqx, sreq}, {1'b0, 4'h0, 4'h0, 1'b0});
    check("single_hold_im", {steali, stealm}, {3'd5, 2'd2});

    // Priority sweep
    req = 4'b1111; tick(); req = 4'h0;
    check("pri_sreqx", sreqx, 4'b1111);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("pri_steal", {steal, sack, steali, stealm}, {1'b1, pri_sack[k], pri_i[k], pri_m[k]});
      tick();
      check("pri_gap", steal, 1'b0);
    end
    check("pri_sreq_done", {sreq, sreqx}, {1'b0, 4'h0});

    // Stall on GO_C=0
    go_c = 1'b0;
    req = 4'b1000; tick(); req = 4'h0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_nosteal", {steal, sreqx}, {1'b0, 4'b1000});
    end
    go_c = 1'b1; tick();
    check("stall_release", {steal, sack, steali, stealm}, {1'b1, 4'b1000, 3'd7, 2'd0});
    tick();

    // STBY also blocks launch
    stby = 1'b1;
    req = 4'b0100; tick(); req = 4'h0;
    tick(); tick(); tick();
    check("stby_nosteal", {steal, sreqx}, {1'b0, 4'b0100});
    stby = 1'b0; tick();
    check("stby_release", {steal, sack}, {1'b1, 4'b0100});
    tick();

    // Overrun and clear
    go_c = 1'b0;
    req = 4'b0010; tick();
    check("ovr_none_first", ovr, 4'h0);
    tick(); req = 4'h0;
    check("ovr_set", ovr, 4'b0010);
    tick(); tick();
    check("ovr_sticky", ovr, 4'b0010);
    ovr_clr = 4'b0010; tick(); ovr_clr = 4'h0;
    check("ovr_cleared", ovr, 4'h0);

    // REQ coincident with sack: request survives, no overrun
    go_c = 1'b1; tick();
    check("coinc_steal", {steal, sack}, {1'b1, 4'b0010});
    req = 4'b0010; tick(); req = 4'h0;
    check("coinc_keep", {sreqx, ovr, steal}, {4'b0010, 4'h0, 1'b0});
    tick();
    check("coinc_resteal", {steal, sack}, {1'b1, 4'b0010});
    tick();
    check("coinc_done", {sreqx, steal}, {4'h0, 1'b0});

    // Wrap to ABINT for R1 only
    req = 4'b0100; tick(); req = 4'h0;
    tick(); tick();
    check("wrap_steal", {steal, sack, abint}, {1'b1, 4'b0100, 4'h0});
    wrap = 4'b0110; tick(); wrap = 4'h0;
    check("wrap_abint", abint, 4'b0100);
    tick();
    check("wrap_abint_pulse", abint, 4'h0);

    // ABEN removal flushes a pending request
    go_c = 1'b0;
    req = 4'b0001; tick(); req = 4'h0;
    aben = 4'h0; tick();
    check("aben_flush", {sreqx, sreq}, {4'h0, 1'b0});
    aben = 4'hF; go_c = 1'b1; tick(); tick();
    check("aben_nosteal", steal, 1'b0);

    // Reset during STEAL
    req = 4'b0001; tick(); tick(); req = 4'h0;
    tick();
    check("rst_pre", {steal, sack, ovr}, {1'b1, 4'b0001, 4'b0001});
    wrap = 4'b0001; rst = 1'b1; tick(); rst = 1'b0; wrap = 4'h0;
    check("rst_mid_steal", {sreqx, sreq, steal, sack, steali, stealm, abint, ovr}, 0);
    tick(); tick(); tick();
    check("rst_no_resteal", {steal, sreq, abint}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
